// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
//   owner_t        : which requester owns the read response due next cycle
//   run_cnt_width  : width of the consecutive-data-grant counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OwnNone,
        OwnIf,
        OwnDrd
    } owner_t;

    // Enough bits to hold 0..max_run inclusive; never narrower than one bit.
    function automatic int unsigned run_cnt_width(input int unsigned max_run);
        return (max_run < 1) ? 1 : $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision for the shared RAM: data wins by default, but after
// MAX_DATA_RUN consecutive data grants with fetch waiting, fetch is granted.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   if_req_i, d_req_i     fetch / data requests
//   if_gnt_o, d_gnt_o     one-hot (or zero) grants for this cycle
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);

    localparam int unsigned CntW = run_cnt_width(MAX_DATA_RUN);
    localparam logic [CntW-1:0] RunMax = CntW'(MAX_DATA_RUN);

    logic [CntW-1:0] run_cnt_q, run_cnt_d;
    logic            at_limit;
    logic            d_gnt;

    assign at_limit = (run_cnt_q >= RunMax);

    always_comb begin
        // Data yields only when fetch is waiting and the run budget is spent.
        d_gnt     = d_req_i & ~(if_req_i & at_limit);
        run_cnt_d = '0;
        if (d_gnt && if_req_i) begin
            run_cnt_d = at_limit ? run_cnt_q : run_cnt_q + 1'b1;
        end
    end

    assign d_gnt_o  = d_gnt;
    assign if_gnt_o = if_req_i & ~d_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the load/store port. Read data (one-cycle latency) is steered back to
// whichever requester owned the previous grant.
// Ports:
//   clk_i, rst_ni                              clock, async active-low reset
//   if_req_i/if_addr_i/if_flush_i              fetch request, address, flush
//   if_gnt_o/if_rvalid_o/if_rdata_o            fetch grant and response
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i   data request
//   d_gnt_o/d_rvalid_o/d_rdata_o               data grant and load response
//   mem_en_o/mem_we_o/mem_be_o/mem_addr_o/mem_wdata_o, mem_rdata_i   RAM side
//   stall_fetch_o/stall_mem_o                  hold requests to hazard unit
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [XLEN-1:0]       if_rdata_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [XLEN/8-1:0]     d_be_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [XLEN-1:0]       d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [XLEN-1:0]       d_rdata_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic [XLEN-1:0]       mem_rdata_i,

    output logic                  stall_fetch_o,
    output logic                  stall_mem_o
);

    owner_t owner_q, owner_d;
    logic   if_gnt, d_gnt;

    mem_arb_prio #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_prio (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .if_gnt_o (if_gnt),
        .d_gnt_o  (d_gnt)
    );

    // Owner of the response due next cycle. if_flush only masks the response
    // returning in the flush cycle; a fetch granted in that same cycle is the
    // redirect target and must come back normally.
    always_comb begin
        owner_d = OwnNone;
        if (if_gnt) begin
            owner_d = OwnIf;
        end else if (d_gnt && !d_we_i) begin
            owner_d = OwnDrd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OwnNone;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt) begin
            mem_en_o   = 1'b1;
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
        end
    end

    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;

    assign if_rvalid_o = (owner_q == OwnIf) & ~if_flush_i;
    assign d_rvalid_o  = (owner_q == OwnDrd);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

    assign stall_fetch_o = if_req_i & ~if_gnt;
    assign stall_mem_o   = d_req_i & ~d_gnt;

endmodule
